alu_cmd_ctrl: RTL and testbench

//  Command-side initiator for the clocked ALU. Takes a byte stream of commands from the

---
 rtl/alu_cmd_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: command-side initiator for a clocked ALU.
//
// Accepts framed commands from a byte stream, drives registered ALU operands and
// function code, waits out the ALU latency, captures result + flags and returns
// a 3-byte response over a valid/ready handshake.
//
// Frames:  0xCC, A_hi, A_lo, B_hi, B_lo, FUN   full operation
//          0xDD, FUN                           reuse current alu_a / alu_b
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   rx_data, rx_valid     incoming command byte + 1-cycle strobe
//   alu_a, alu_b, alu_fun registered ALU operands / function code
//   alu_out, alu_flags    ALU result and {arith, logic, cmp, shift} flags
//   tx_data, tx_valid,    response byte stream (valid/ready)
//   tx_ready
//   busy                  high whenever not idle
//   cmd_err               1-cycle pulse: bad opcode or frame timeout
//   rx_ovr                1-cycle pulse: byte dropped while computing/responding
module alu_cmd_ctrl #(
    parameter int unsigned ALU_LAT     = 1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_fun,
    input  logic [16:0] alu_out,
    input  logic [3:0]  alu_flags,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        cmd_err,
    output logic        rx_ovr
);

    localparam logic [7:0] OpFull  = 8'hCC;
    localparam logic [7:0] OpReuse = 8'hDD;

    typedef enum logic [3:0] {
        StIdle,
        StGetAh,
        StGetAl,
        StGetBh,
        StGetBl,
        StGetFun,
        StAluWait,
        StSend0,
        StSend1,
        StSend2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] a_sh_q, a_sh_d;
    logic [15:0] b_sh_q, b_sh_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_fun_q, alu_fun_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        cmd_err_q, cmd_err_d;
    logic        rx_ovr_q, rx_ovr_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [20:0] res_q, res_d;
    logic        in_get;

    assign in_get = (state_q == StGetAh) || (state_q == StGetAl) || (state_q == StGetBh) ||
                    (state_q == StGetBl) || (state_q == StGetFun);

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_fun_d  = alu_fun_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        cmd_err_d  = 1'b0;
        rx_ovr_d   = 1'b0;
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = 16'd0;
        res_d      = res_q;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (rx_data == OpFull) begin
                        state_d = StGetAh;
                    end else if (rx_data == OpReuse) begin
                        // Seed the shadows so the FUN byte commits the unchanged operands.
                        a_sh_d  = alu_a_q;
                        b_sh_d  = alu_b_q;
                        state_d = StGetFun;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            StGetAh: begin
                if (rx_valid) begin
                    a_sh_d[15:8] = rx_data;
                    state_d      = StGetAl;
                end
            end
            StGetAl: begin
                if (rx_valid) begin
                    a_sh_d[7:0] = rx_data;
                    state_d     = StGetBh;
                end
            end
            StGetBh: begin
                if (rx_valid) begin
                    b_sh_d[15:8] = rx_data;
                    state_d      = StGetBl;
                end
            end
            StGetBl: begin
                if (rx_valid) begin
                    b_sh_d[7:0] = rx_data;
                    state_d     = StGetFun;
                end
            end
            StGetFun: begin
                if (rx_valid) begin
                    // Operands and function commit on the same edge.
                    alu_a_d    = a_sh_q;
                    alu_b_d    = b_sh_q;
                    alu_fun_d  = rx_data[3:0];
                    wait_cnt_d = 3'd0;
                    state_d    = StAluWait;
                end
            end
            StAluWait: begin
                rx_ovr_d = rx_valid;
                // wait_cnt_q == k-1 at the k-th edge after FUN; capture at edge ALU_LAT+1.
                if (wait_cnt_q == 3'(ALU_LAT)) begin
                    res_d      = {alu_flags, alu_out};
                    tx_data_d  = {3'b000, alu_flags, alu_out[16]};
                    tx_valid_d = 1'b1;
                    wait_cnt_d = 3'd0;
                    state_d    = StSend0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            StSend0: begin
                rx_ovr_d = rx_valid;
                if (tx_ready) begin
                    tx_data_d = res_q[15:8];
                    state_d   = StSend1;
                end
            end
            StSend1: begin
                rx_ovr_d = rx_valid;
                if (tx_ready) begin
                    tx_data_d = res_q[7:0];
                    state_d   = StSend2;
                end
            end
            StSend2: begin
                rx_ovr_d = rx_valid;
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Inter-byte timeout; a byte in this cycle always wins over expiry.
        if (in_get && !rx_valid) begin
            if (to_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                state_d   = StIdle;
                cmd_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            a_sh_q     <= 16'd0;
            b_sh_q     <= 16'd0;
            alu_a_q    <= 16'd0;
            alu_b_q    <= 16'd0;
            alu_fun_q  <= 4'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            wait_cnt_q <= 3'd0;
            to_cnt_q   <= 16'd0;
            res_q      <= 21'd0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_fun_q  <= alu_fun_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cmd_err_q  <= cmd_err_d;
            rx_ovr_q   <= rx_ovr_d;
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
            res_q      <= res_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_fun  = alu_fun_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign cmd_err  = cmd_err_q;
    assign rx_ovr   = rx_ovr_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a small registered ALU model (latency 1).
module tb_alu_cmd_ctrl;

    localparam int unsigned TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic [16:0] alu_out;
    logic [3:0]  alu_flags;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy, cmd_err, rx_ovr;

    int checks = 0;
    int errors = 0;
    logic [7:0] got [3];
    int got_n;

    alu_cmd_ctrl #(
        .ALU_LAT    (1),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_fun  (alu_fun),
        .alu_out  (alu_out),
        .alu_flags(alu_flags),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .cmd_err  (cmd_err),
        .rx_ovr   (rx_ovr)
    );

    always #5 clk = ~clk;

    // ALU model: fun[3:2] selects the group that raises its flag.
    function automatic logic [20:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] f);
        logic [16:0] r;
        logic [16:0] ax, bx;
        logic [3:0]  fl;
        ax = {1'b0, a};
        bx = {1'b0, b};
        case (f)
            4'd0:    r = ax + bx;
            4'd1:    r = ax - bx;
            4'd2:    r = ax * bx;
            4'd4:    r = ax & bx;
            4'd5:    r = ax | bx;
            default: r = 17'd0;
        endcase
        fl = {f[3:2] == 2'd0, f[3:2] == 2'd1, f[3:2] == 2'd2, f[3:2] == 2'd3};
        return {fl, r};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {alu_flags, alu_out} <= 21'd0;
        else     {alu_flags, alu_out} <= alu_calc(alu_a, alu_b, alu_fun);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Called at a negedge; collects n bytes with tx_ready as currently driven (high).
    task automatic collect(input int n);
        got_n = 0;
        for (int c = 0; c < 60 && got_n < n; c++) begin
            if (tx_valid) begin
                got[got_n] = tx_data;
                got_n++;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input string tag);
        int c;
        c = 0;
        while (!tx_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk(tag, {31'd0, tx_valid}, 32'd1);
    endtask

    initial begin
        logic stable;
        int   n;

        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("rst_alu_fun", {28'd0, alu_fun}, 32'd0);
        chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);

        // 1: ADD 15 + 10
        tx_ready = 1'b1;
        send_byte(8'hCC); send_byte(8'h00); send_byte(8'h0F);
        send_byte(8'h00); send_byte(8'h0A); send_byte(8'h00);
        chk("t1_busy_during", {31'd0, busy}, 32'd1);
        collect(3);
        chk("t1_count", got_n, 32'd3);
        chk("t1_b0", {24'd0, got[0]}, 32'h10);
        chk("t1_b1", {24'd0, got[1]}, 32'h00);
        chk("t1_b2", {24'd0, got[2]}, 32'h19);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);
        chk("t1_tx_valid_after", {31'd0, tx_valid}, 32'd0);

        // 2: MUL reusing operands
        send_byte(8'hDD); send_byte(8'hF2);
        collect(3);
        chk("t2_count", got_n, 32'd3);
        chk("t2_b0", {24'd0, got[0]}, 32'h10);
        chk("t2_b1", {24'd0, got[1]}, 32'h00);
        chk("t2_b2", {24'd0, got[2]}, 32'h96);
        chk("t2_alu_a", {16'd0, alu_a}, 32'd15);
        chk("t2_alu_b", {16'd0, alu_b}, 32'd10);
        chk("t2_alu_fun", {28'd0, alu_fun}, 32'd2);

        // 3: bad opcode
        send_byte(8'h55);
        chk("t3_cmd_err", {31'd0, cmd_err}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("t3_cmd_err_pulse", {31'd0, cmd_err}, 32'd0);
        chk("t3_tx_valid", {31'd0, tx_valid}, 32'd0);

        // 4: timeout mid-frame
        send_byte(8'hCC); send_byte(8'h00);
        n = 0;
        while (!cmd_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t4_timeout_cycles", n, TO_CYC);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_alu_a_kept", {16'd0, alu_a}, 32'd15);
        @(negedge clk);
        chk("t4_cmd_err_pulse", {31'd0, cmd_err}, 32'd0);

        // 5: backpressure during SEND1, overrun byte; SUB 7 - 3
        tx_ready = 1'b0;
        send_byte(8'hCC); send_byte(8'h00); send_byte(8'h07);
        send_byte(8'h00); send_byte(8'h03); send_byte(8'h01);
        wait_valid("t5_valid");
        chk("t5_b0", {24'd0, tx_data}, 32'h10);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                rx_data  = 8'hAA;
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            @(negedge clk);
            if (tx_data !== 8'h00 || tx_valid !== 1'b1) stable = 1'b0;
            if (i == 5) chk("t5_rx_ovr", {31'd0, rx_ovr}, 32'd1);
            if (i == 6) chk("t5_rx_ovr_pulse", {31'd0, rx_ovr}, 32'd0);
        end
        chk("t5_hold_stable", {31'd0, stable}, 32'd1);
        tx_ready = 1'b1;
        collect(2);
        chk("t5_count", got_n, 32'd2);
        chk("t5_b1", {24'd0, got[0]}, 32'h00);
        chk("t5_b2", {24'd0, got[1]}, 32'h04);
        chk("t5_busy_after", {31'd0, busy}, 32'd0);

        // 6: reset during SEND1
        tx_ready = 1'b0;
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56); send_byte(8'h78); send_byte(8'h00);
        wait_valid("t6_valid");
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("t6_in_send1", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("t6_rst_tx_data", {24'd0, tx_data}, 32'h00);
        chk("t6_rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("t6_rst_alu_b", {16'd0, alu_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_no_resume", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b1;
        send_byte(8'hDD); send_byte(8'h00);
        collect(3);
        chk("t6_count", got_n, 32'd3);
        chk("t6_b0", {24'd0, got[0]}, 32'h10);
        chk("t6_b1", {24'd0, got[1]}, 32'h00);
        chk("t6_b2", {24'd0, got[2]}, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
